// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the ALU datapath and the control decoder.
//
// Contents:
//   ALU_W / ALU_OP_W    : datapath and opcode widths
//   ALU_ADD .. ALU_GEU  : ALUctr opcode values
//   shift_mode_e        : selects the shift performed by alu_shifter
//   alu_op_is_defined() : 1 for opcodes that produce a defined result
package alu_pkg;

  localparam int ALU_W    = 32;
  localparam int ALU_OP_W = 6;
  localparam int SHAMT_W  = 5;

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = 6'h00;
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = 6'h01;
  localparam logic [ALU_OP_W-1:0] ALU_SLL   = 6'h02;
  localparam logic [ALU_OP_W-1:0] ALU_SLT   = 6'h03;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU  = 6'h04;
  localparam logic [ALU_OP_W-1:0] ALU_XOR   = 6'h05;
  localparam logic [ALU_OP_W-1:0] ALU_SRL   = 6'h06;
  localparam logic [ALU_OP_W-1:0] ALU_SRA   = 6'h07;
  localparam logic [ALU_OP_W-1:0] ALU_OR    = 6'h08;
  localparam logic [ALU_OP_W-1:0] ALU_AND   = 6'h09;
  localparam logic [ALU_OP_W-1:0] ALU_PASSB = 6'h0A;
  localparam logic [ALU_OP_W-1:0] ALU_EQ    = 6'h0B;
  localparam logic [ALU_OP_W-1:0] ALU_NE    = 6'h0C;
  localparam logic [ALU_OP_W-1:0] ALU_LT    = 6'h0D;
  localparam logic [ALU_OP_W-1:0] ALU_GE    = 6'h0E;
  localparam logic [ALU_OP_W-1:0] ALU_LTU   = 6'h0F;
  localparam logic [ALU_OP_W-1:0] ALU_GEU   = 6'h10;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'd0,
    SHIFT_SRL = 2'd1,
    SHIFT_SRA = 2'd2
  } shift_mode_e;

  // Opcodes above ALU_GEU are reserved and yield res = 0.
  function automatic logic alu_op_is_defined(input logic [ALU_OP_W-1:0] op);
    return (op <= ALU_GEU);
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter -- barrel shifter for SLL / SRL / SRA.
//
// Ports:
//   data_i  [31:0] : value to shift (rs1)
//   shamt_i [4:0]  : shift amount; 0 returns data_i unchanged
//   mode_i         : shift_mode_e (logical left, logical right, arithmetic right)
//   data_o  [31:0] : shifted result (combinational)
module alu_shifter
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0]   data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  shift_mode_e        mode_i,
  output logic [ALU_W-1:0]   data_o
);

  always_comb begin
    data_o = '0;
    unique case (mode_i)
      SHIFT_SLL: data_o = data_i << shamt_i;
      SHIFT_SRL: data_o = data_i >> shamt_i;
      SHIFT_SRA: data_o = $unsigned($signed(data_i) >>> shamt_i);
      default:   data_o = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// alu -- 32-bit integer ALU with a combinational result and a registered copy.
//
// Ports:
//   clk          : rising-edge clock
//   rst          : synchronous active-high reset (registered outputs only)
//   ALUctr [5:0] : operation select (see alu_pkg opcodes)
//   rs1    [31:0]: operand A
//   rs2    [31:0]: operand B
//   res    [31:0]: combinational result
//   zero         : combinational, 1 iff res == 0
//   res_q  [31:0]: res captured on the previous rising edge (0 after reset)
//   zero_q       : zero captured on the previous rising edge (1 after reset)
module alu
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [ALU_OP_W-1:0] ALUctr,
  input  logic [ALU_W-1:0]    rs1,
  input  logic [ALU_W-1:0]    rs2,
  output logic [ALU_W-1:0]    res,
  output logic                zero,
  output logic [ALU_W-1:0]    res_q,
  output logic                zero_q
);

  shift_mode_e       shift_mode;
  logic [ALU_W-1:0]  shift_res;
  logic              eq;
  logic              lt_s;
  logic              lt_u;
  logic              cond;
  logic [ALU_W-1:0]  res_d;
  logic              zero_d;

  // Only rs2[4:0] reaches the shifter; upper bits are ignored by design.
  always_comb begin
    shift_mode = SHIFT_SLL;
    if (ALUctr == ALU_SRL) shift_mode = SHIFT_SRL;
    if (ALUctr == ALU_SRA) shift_mode = SHIFT_SRA;
  end

  alu_shifter u_shifter (
    .data_i  (rs1),
    .shamt_i (rs2[SHAMT_W-1:0]),
    .mode_i  (shift_mode),
    .data_o  (shift_res)
  );

  // Shared comparators feed both the SLT/SLTU set ops and the branch-style
  // compare ops.
  always_comb begin
    eq   = (rs1 == rs2);
    lt_s = ($signed(rs1) < $signed(rs2));
    lt_u = (rs1 < rs2);
  end

  always_comb begin
    cond = 1'b0;
    unique case (ALUctr)
      ALU_SLT, ALU_LT:  cond = lt_s;
      ALU_SLTU, ALU_LTU: cond = lt_u;
      ALU_EQ:           cond = eq;
      ALU_NE:           cond = ~eq;
      ALU_GE:           cond = ~lt_s;
      ALU_GEU:          cond = ~lt_u;
      default:          cond = 1'b0;
    endcase
  end

  // Result mux. Carries and overflow are discarded; reserved opcodes give 0.
  always_comb begin
    res = '0;
    if (alu_op_is_defined(ALUctr)) begin
      unique case (ALUctr)
        ALU_ADD:   res = rs1 + rs2;
        ALU_SUB:   res = rs1 - rs2;
        ALU_SLL,
        ALU_SRL,
        ALU_SRA:   res = shift_res;
        ALU_XOR:   res = rs1 ^ rs2;
        ALU_OR:    res = rs1 | rs2;
        ALU_AND:   res = rs1 & rs2;
        ALU_PASSB: res = rs2;
        ALU_SLT, ALU_SLTU, ALU_EQ, ALU_NE,
        ALU_LT, ALU_GE, ALU_LTU, ALU_GEU:
                   res = {{(ALU_W-1){1'b0}}, cond};
        default:   res = '0;
      endcase
    end
  end

  always_comb begin
    zero = (res == '0);
  end

  // Capture path: reset is handled in the flop so it wins over capture and
  // never disturbs the combinational outputs.
  always_comb begin
    res_d  = res;
    zero_d = zero;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      res_q  <= res_d;
      zero_q <= zero_d;
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb_alu -- self-checking bench for alu: directed cases plus random operations
// compared against a behavioural model; registered outputs are checked through
// an expected queue, one entry per clock edge.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [5:0]  alu_ctr;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] res;
  logic        zero;
  logic [31:0] res_q;
  logic        zero_q;

  int checks = 0;
  int errors = 0;

  // {zero, res} expected on the registered outputs after the next edge
  logic [32:0] exp_q[$];

  alu dut (
    .clk    (clk),
    .rst    (rst),
    .ALUctr (alu_ctr),
    .rs1    (rs1),
    .rs2    (rs2),
    .res    (res),
    .zero   (zero),
    .res_q  (res_q),
    .zero_q (zero_q)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_alu(input logic [5:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    logic [31:0] sa;
    logic [31:0] sb;
    logic [31:0] r;
    sh = b % 32;
    // Flipping the sign bit turns a signed order into an unsigned one.
    sa = a ^ 32'h8000_0000;
    sb = b ^ 32'h8000_0000;
    r  = 32'h0;
    case (op)
      6'h00: r = a + b;
      6'h01: r = a - b;
      6'h02: r = a << sh;
      6'h03: r = (sa < sb) ? 32'd1 : 32'd0;
      6'h04: r = (a < b) ? 32'd1 : 32'd0;
      6'h05: r = a ^ b;
      6'h06: r = a >> sh;
      6'h07: r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      6'h08: r = a | b;
      6'h09: r = a & b;
      6'h0A: r = b;
      6'h0B: r = (a == b) ? 32'd1 : 32'd0;
      6'h0C: r = (a != b) ? 32'd1 : 32'd0;
      6'h0D: r = (sa < sb) ? 32'd1 : 32'd0;
      6'h0E: r = (sa >= sb) ? 32'd1 : 32'd0;
      6'h0F: r = (a < b) ? 32'd1 : 32'd0;
      6'h10: r = (a >= b) ? 32'd1 : 32'd0;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Drives one operation after the falling edge, checks the combinational
  // outputs, then checks the registered outputs just after the rising edge.
  task automatic step(input logic [5:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic r,
                      input logic [31:0] want_res);
    logic [32:0] e;
    @(negedge clk);
    alu_ctr = op;
    rs1     = a;
    rs2     = b;
    rst     = r;
    #1;
    check($sformatf("res op=%h a=%h b=%h", op, a, b), res, want_res);
    check($sformatf("zero op=%h a=%h b=%h", op, a, b), {31'b0, zero},
          {31'b0, (want_res == 32'h0)});
    exp_q.push_back(r ? {1'b1, 32'h0} : {(want_res == 32'h0), want_res});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check($sformatf("res_q op=%h rst=%0b", op, r), res_q, e[31:0]);
    check($sformatf("zero_q op=%h rst=%0b", op, r), {31'b0, zero_q}, {31'b0, e[32]});
  endtask

  task automatic step_model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    step(op, a, b, 1'b0, ref_alu(op, a, b));
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return $urandom_range(0, 40);
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    rst     = 1'b1;
    alu_ctr = 6'h00;
    rs1     = 32'd0;
    rs2     = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset res_q", res_q, 32'h0);
    check("reset zero_q", {31'b0, zero_q}, 32'd1);

    // Directed: fixed expected values
    step(6'h00, 32'd2, 32'd1, 1'b0, 32'd3);
    step(6'h01, 32'd3, 32'd2, 1'b0, 32'd1);
    step(6'h01, 32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF);
    step(6'h01, 32'd5, 32'd5, 1'b0, 32'h0);
    step(6'h00, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0);
    step(6'h07, 32'h8000_0000, 32'h21, 1'b0, 32'hC000_0000);
    step(6'h06, 32'h8000_0000, 32'h21, 1'b0, 32'h4000_0000);
    step(6'h02, 32'h1234_5678, 32'hFFFF_FFE0, 1'b0, 32'h1234_5678);
    step(6'h02, 32'h0000_0001, 32'd31, 1'b0, 32'h8000_0000);
    step(6'h03, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd1);
    step(6'h04, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0);
    step(6'h0E, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0);
    step(6'h10, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd1);
    step(6'h0A, 32'hDEAD_BEEF, 32'hABCD_0000, 1'b0, 32'hABCD_0000);
    step(6'h3F, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 32'h0);
    step(6'h11, 32'd7, 32'd9, 1'b0, 32'h0);

    // Reset over an edge while res=3, then resume capture
    step(6'h00, 32'd2, 32'd1, 1'b0, 32'd3);
    step(6'h00, 32'd2, 32'd1, 1'b1, 32'd3);
    step(6'h00, 32'd2, 32'd1, 1'b0, 32'd3);

    // Random operations against the model
    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(17, 63))
                                       : 6'($urandom_range(0, 16));
      a  = rand_operand();
      b  = rand_operand();
      if ($urandom_range(0, 7) == 0) b = a;
      step_model(op, a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: ALU

Interface
REQ-001 Parameters: none; datapath fixed at 32 bits, opcode at 6 bits.
REQ-002 clk  input  1  single clock, rising-edge active.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ALUctr  input  6  operation select.
REQ-005 rs1  input  32  operand A.
REQ-006 rs2  input  32  operand B.
REQ-007 res  output  32  combinational result of current ALUctr/rs1/rs2.
REQ-008 zero  output  1  combinational; 1 iff res == 0.
REQ-009 res_q  output  32  registered copy of res.
REQ-010 zero_q  output  1  registered copy of zero.

Function
REQ-011 res SHALL be purely combinational from ALUctr, rs1, rs2; zero-cycle latency, independent of clk/rst.
REQ-012 ALUctr encoding SHALL be:
- 0x00 ADD: rs1+rs2, mod 2^32, carry discarded.
- 0x01 SUB: rs1-rs2, mod 2^32.
- 0x02 SLL: rs1 << rs2[4:0].
- 0x03 SLT: signed rs1<rs2 ? 1 : 0.
- 0x04 SLTU: unsigned rs1<rs2 ? 1 : 0.
- 0x05 XOR.
- 0x06 SRL: logical rs1 >> rs2[4:0].
- 0x07 SRA: arithmetic rs1 >> rs2[4:0], sign-filled.
- 0x08 OR.
- 0x09 AND.
- 0x0A PASSB: res = rs2 (LUI).
- 0x0B EQ, 0x0C NE, 0x0D LT (signed), 0x0E GE (signed), 0x0F LTU, 0x10 GEU: res = 1 if condition true, else 0.
REQ-013 Shift ops SHALL use only rs2[4:0]; rs2[31:5] ignored; shift amount 0 returns rs1 unchanged.
REQ-014 Compare/set results SHALL be zero-extended to 32 bits (bit 0 only).
REQ-015 Undefined ALUctr values (0x11-0x3F) SHALL yield res = 0, zero = 1.
REQ-016 Overflow SHALL NOT be flagged; ADD/SUB wrap silently.
REQ-017 On each rising clk edge with rst=0, res_q <= res and zero_q <= zero (one-cycle latency).

Reset
REQ-018 On rising clk with rst=1: res_q <= 0, zero_q <= 1; reset SHALL take priority over capture.
REQ-019 rst SHALL NOT affect combinational res/zero.
REQ-020 Deasserting rst SHALL resume capture on the next rising edge.

Structure
REQ-021 Opcode localparams (ALU_ADD ... ALU_GEU) SHALL live in a shared package alu_pkg, also used by the control decoder.
REQ-022 One sub-module alu_shifter (SLL/SRL/SRA on rs1, shamt[4:0], mode) is natural; everything else stays in ALU.

Verification
REQ-023 ALUctr=0x00, rs1=2, rs2=1 -> res=3, zero=0; after next clk res_q=3.
REQ-024 ALUctr=0x01, rs1=3, rs2=2 -> res=1; rs1=0, rs2=1 -> res=0xFFFFFFFF; rs1=rs2=5 -> zero=1.
REQ-025 ALUctr=0x07, rs1=0x80000000, rs2=0x21 -> res=0xC0000000 (shamt 1); 0x06 same operands -> 0x40000000.
REQ-026 rs1=0xFFFFFFFF, rs2=1: SLT -> 1, SLTU -> 0, GE -> 0, GEU -> 1.
REQ-027 ALUctr=0x3F, any operands -> res=0, zero=1.
REQ-028 rst=1 over a clk edge while res=3 -> res_q=0, zero_q=1, res still 3; rst=0 -> res_q=3 after next edge.
